// File: rtl/gb_run_ctrl.sv
// gb_run_ctrl: run / halt / single-step / breakpoint controller for the GB core.
// Parses UART command bytes, gates the GB machine tick into gb_ce, compares the
// CPU debug PC against a programmable breakpoint, and reports ack / NAK /
// step-complete / breakpoint bytes through a 1-deep TX holding register.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_data, rx_valid   received command/argument byte, one-cycle strobe
//   gb_tick             one-cycle strobe per GB machine clock period
//   pc                  CPU PC, stable whenever gb_tick=1
//   gb_ce               gated tick to the core
//   halted              exec FSM is in HALT
//   bp_hit              one-cycle pulse the cycle after a breakpoint halt
//   tx_data, tx_valid   pending byte to the transmitter
//   tx_ready            transmitter accepts when tx_valid & tx_ready
//   tx_ovf              sticky: a message was dropped
module gb_run_ctrl #(
    parameter bit RESET_HALTED = 1'b0,
    parameter int ARG_TIMEOUT  = 5000000,
    parameter int TO_W         = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        gb_tick,
    input  logic [15:0] pc,
    output logic        gb_ce,
    output logic        halted,
    output logic        bp_hit,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_ovf
);

    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_B = 8'h42;
    localparam logic [7:0] MSG_ACK  = 8'h06;
    localparam logic [7:0] MSG_NAK  = 8'h15;
    localparam logic [7:0] MSG_STEP = 8'h2E;
    localparam logic [7:0] MSG_BP   = 8'h21;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ARG_TIMEOUT - 1);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} exec_t;
    typedef enum logic [1:0] {P_IDLE, P_ARG_HI, P_ARG_LO} parse_t;

    exec_t           exec;
    parse_t          parse;
    logic            cmd_step;   // 1: collecting 'S' args, 0: collecting 'B' args
    logic [7:0]      arg_hi;
    logic [TO_W-1:0] to_cnt;
    logic [15:0]     step_cnt;
    logic [15:0]     bp_addr;
    logic            bp_en;
    logic            skip;       // ignore breakpoint until the next passed tick

    logic       bp_match, can_run, bp_event, step_done, to_abort;
    logic       resp_vld, msg_vld, msg_collide, tx_busy;
    logic [7:0] resp_byte, msg_byte;

    assign halted   = (exec == S_HALT);
    assign bp_match = bp_en & ~skip & (pc == bp_addr);
    assign can_run  = (exec == S_RUN) | ((exec == S_STEP) & (step_cnt != 16'd0));
    assign gb_ce    = gb_tick & can_run & ~bp_match;
    assign bp_event = gb_tick & can_run & bp_match;
    assign step_done = gb_ce & (exec == S_STEP) & (step_cnt == 16'd1);
    assign to_abort = ~rx_valid & (parse != P_IDLE) & (to_cnt == TO_LAST);

    // Parser response: ack on completed command, NAK on unknown byte or timeout.
    always_comb begin
        resp_vld  = 1'b0;
        resp_byte = MSG_ACK;
        if (rx_valid) begin
            case (parse)
                P_IDLE: begin
                    case (rx_data)
                        CMD_H, CMD_R, CMD_C: resp_vld = 1'b1;
                        CMD_S, CMD_B: ;
                        default: begin
                            resp_vld  = 1'b1;
                            resp_byte = MSG_NAK;
                        end
                    endcase
                end
                P_ARG_LO: resp_vld = 1'b1;
                default: ;
            endcase
        end else if (to_abort) begin
            resp_vld  = 1'b1;
            resp_byte = MSG_NAK;
        end
    end

    // Priority: breakpoint > step-complete > ack/NAK; losers are dropped.
    assign msg_vld     = bp_event | step_done | resp_vld;
    assign msg_byte    = bp_event ? MSG_BP : (step_done ? MSG_STEP : resp_byte);
    assign msg_collide = (bp_event & (step_done | resp_vld)) | (step_done & resp_vld);
    assign tx_busy     = tx_valid & ~tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            exec     <= RESET_HALTED ? S_HALT : S_RUN;
            parse    <= P_IDLE;
            cmd_step <= 1'b0;
            arg_hi   <= 8'h00;
            to_cnt   <= '0;
            step_cnt <= 16'd0;
            bp_addr  <= 16'd0;
            bp_en    <= 1'b0;
            skip     <= 1'b0;
            bp_hit   <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            tx_ovf   <= 1'b0;
        end else begin
            bp_hit <= bp_event;

            // Tick effects use the pre-command state; command updates below win.
            if (gb_ce) begin
                skip <= 1'b0;
                if (exec == S_STEP) begin
                    step_cnt <= step_cnt - 16'd1;
                    if (step_done)
                        exec <= S_HALT;
                end
            end

            if (rx_valid) begin
                to_cnt <= '0;
                case (parse)
                    P_IDLE: begin
                        case (rx_data)
                            CMD_H: exec  <= S_HALT;
                            CMD_R: exec  <= S_RUN;
                            CMD_C: bp_en <= 1'b0;
                            CMD_S: begin
                                cmd_step <= 1'b1;
                                parse    <= P_ARG_HI;
                            end
                            CMD_B: begin
                                cmd_step <= 1'b0;
                                parse    <= P_ARG_HI;
                            end
                            default: ;
                        endcase
                    end
                    P_ARG_HI: begin
                        arg_hi <= rx_data;
                        parse  <= P_ARG_LO;
                    end
                    P_ARG_LO: begin
                        parse <= P_IDLE;
                        if (cmd_step) begin
                            step_cnt <= {arg_hi, rx_data};
                            exec     <= ({arg_hi, rx_data} == 16'd0) ? S_HALT : S_STEP;
                        end else begin
                            bp_addr <= {arg_hi, rx_data};
                            bp_en   <= 1'b1;
                            skip    <= 1'b0;
                        end
                    end
                    default: parse <= P_IDLE;
                endcase
            end else if (parse != P_IDLE) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_abort)
                    parse <= P_IDLE;
            end

            // A breakpoint halts regardless of any command in the same cycle.
            if (bp_event) begin
                exec <= S_HALT;
                skip <= 1'b1;
            end

            if (tx_valid & tx_ready)
                tx_valid <= 1'b0;
            if (msg_vld) begin
                if (tx_busy) begin
                    tx_ovf <= 1'b1;
                end else begin
                    tx_valid <= 1'b1;
                    tx_data  <= msg_byte;
                end
            end
            if (msg_collide)
                tx_ovf <= 1'b1;
        end
    end

endmodule
